parking_slot_manager: RTL and testbench

//   Owns the parking-lot occupancy bitmap and produces the parking_capacity vector for the entry checker.

---
 rtl/parking_pkg.sv | 15 +
 rtl/parking_slot_manager_encoder.sv | 20 ++
 rtl/parking_slot_manager.sv | 108 ++++++++++
 tb/tb_parking_slot_manager.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared sizing defaults, FSM state encoding and slot-index type for the parking-lot slot manager.
package parking_pkg;

  localparam int unsigned N_SLOTS          = 8;
  localparam int unsigned SLOT_W           = 3;
  localparam int unsigned GATE_OPEN_CYCLES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  typedef logic [SLOT_W-1:0] slot_idx_t;

endpackage

// File: rtl/parking_slot_manager_encoder.sv
// Lowest-set-bit priority encoder over the free-slot mask; bit 0 has the highest priority.
module lowest_free_encoder #(
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned SLOT_W  = 3
) (
  input  logic [N_SLOTS-1:0] free_mask,
  output logic [SLOT_W-1:0]  idx,
  output logic               any_free
);

  // Scan from the top down so the last (lowest) free index wins.
  always_comb begin
    idx      = '0;
    any_free = |free_mask;
    for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
      if (free_mask[i]) idx = SLOT_W'(i);
    end
  end

endmodule

// File: rtl/parking_slot_manager.sv
// Parking-lot occupancy bitmap owner: allocates the lowest free slot on admitted entry,
// frees slots on exit and times the entry gate-open pulse.
module parking_slot_manager
  import parking_pkg::*;
#(
  parameter int unsigned N_SLOTS          = parking_pkg::N_SLOTS,
  parameter int unsigned SLOT_W           = parking_pkg::SLOT_W,
  parameter int unsigned GATE_OPEN_CYCLES = parking_pkg::GATE_OPEN_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               entry_req,
  input  logic               entry_enable,
  input  logic               exit_req,
  input  logic [SLOT_W-1:0]  exit_slot,
  output logic [N_SLOTS-1:0] parking_capacity,
  output logic [SLOT_W:0]    free_count,
  output logic               entry_grant,
  output logic [SLOT_W-1:0]  grant_slot,
  output logic               gate_open,
  output logic               exit_err
);

  localparam int unsigned TIMER_W = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;

  state_t               r_state;
  logic [TIMER_W-1:0]   r_timer;
  logic [N_SLOTS-1:0]   r_cap;
  logic [SLOT_W:0]      r_free;
  logic                 r_grant;
  logic [SLOT_W-1:0]    r_grant_slot;
  logic                 r_gate;
  logic                 r_err;

  logic [SLOT_W-1:0]    w_free_idx;
  logic                 w_any_free;
  logic                 w_alloc;
  logic                 w_exit_ok;
  logic [N_SLOTS-1:0]   w_alloc_mask;
  logic [N_SLOTS-1:0]   w_exit_mask;

  lowest_free_encoder #(
    .N_SLOTS (N_SLOTS),
    .SLOT_W  (SLOT_W)
  ) u_enc (
    .free_mask (~r_cap),
    .idx       (w_free_idx),
    .any_free  (w_any_free)
  );

  // An out-of-range exit slot shifts to an all-zero mask, so it reads as "not occupied".
  always_comb begin
    w_exit_mask  = N_SLOTS'(1) << exit_slot;
    w_exit_ok    = exit_req && ((r_cap & w_exit_mask) != '0);
    w_alloc      = (r_state == IDLE) && entry_req && entry_enable && w_any_free;
    w_alloc_mask = w_alloc ? (N_SLOTS'(1) << w_free_idx) : '0;
  end

  // Allocation searches the pre-exit bitmap, so the allocated and freed slots never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_cap        <= '0;
      r_free       <= (SLOT_W+1)'(N_SLOTS);
      r_grant      <= 1'b0;
      r_grant_slot <= '0;
      r_gate       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_grant <= w_alloc;
      r_err   <= exit_req && !w_exit_ok;
      r_cap   <= (r_cap | w_alloc_mask) & ~(w_exit_ok ? w_exit_mask : '0);
      r_free  <= r_free - (SLOT_W+1)'(w_alloc) + (SLOT_W+1)'(w_exit_ok);
      if (w_alloc) r_grant_slot <= w_free_idx;

      case (r_state)
        IDLE: begin
          if (w_alloc) begin
            r_state <= GATE;
            r_gate  <= 1'b1;
            r_timer <= TIMER_W'(GATE_OPEN_CYCLES - 1);
          end
        end
        GATE: begin
          if (r_timer == '0) begin
            r_state <= IDLE;
            r_gate  <= 1'b0;
          end else begin
            r_timer <= r_timer - TIMER_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gate  <= 1'b0;
        end
      endcase
    end
  end

  assign parking_capacity = r_cap;
  assign free_count       = r_free;
  assign entry_grant      = r_grant;
  assign grant_slot       = r_grant_slot;
  assign gate_open        = r_gate;
  assign exit_err         = r_err;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed plus randomized bench for parking_slot_manager against a slot-array reference model.
module tb_parking_slot_manager;
  import parking_pkg::*;

  localparam int unsigned NS  = N_SLOTS;
  localparam int unsigned GOC = GATE_OPEN_CYCLES;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              entry_req;
  logic              entry_enable;
  logic              exit_req;
  logic [SLOT_W-1:0] exit_slot;
  logic [NS-1:0]     parking_capacity;
  logic [SLOT_W:0]   free_count;
  logic              entry_grant;
  logic [SLOT_W-1:0] grant_slot;
  logic              gate_open;
  logic              exit_err;

  always #5 clk = ~clk;

  parking_slot_manager dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .entry_req        (entry_req),
    .entry_enable     (entry_enable),
    .exit_req         (exit_req),
    .exit_slot        (exit_slot),
    .parking_capacity (parking_capacity),
    .free_count       (free_count),
    .entry_grant      (entry_grant),
    .grant_slot       (grant_slot),
    .gate_open        (gate_open),
    .exit_err         (exit_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one flag per slot, gate as "cycles of open left".
  bit        m_occ [NS];
  int        m_gate_left;
  bit        m_grant;
  slot_idx_t m_slot;
  bit        m_err;

  function automatic int m_free();
    int c = 0;
    for (int i = 0; i < int'(NS); i++) if (!m_occ[i]) c++;
    return c;
  endfunction

  function automatic logic [NS-1:0] m_cap();
    logic [NS-1:0] v = '0;
    for (int i = 0; i < int'(NS); i++) v[i] = m_occ[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NS); i++) m_occ[i] = 1'b0;
    m_gate_left = 0;
    m_grant     = 1'b0;
    m_slot      = '0;
    m_err       = 1'b0;
  endtask

  task automatic model_edge();
    int  low  = -1;
    bit  busy = (m_gate_left > 0);
    bit  alloc;
    bit  ex_ok;
    for (int i = 0; i < int'(NS); i++) if (!m_occ[i] && low < 0) low = i;
    alloc = !busy && entry_req && entry_enable && (low >= 0);
    ex_ok = exit_req && (int'(exit_slot) < int'(NS)) && m_occ[exit_slot];
    if (busy) m_gate_left--;
    m_grant = alloc;
    m_err   = exit_req && !ex_ok;
    if (ex_ok) m_occ[exit_slot] = 1'b0;
    if (alloc) begin
      m_occ[low]  = 1'b1;
      m_slot      = SLOT_W'(low);
      m_gate_left = int'(GOC);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".capacity"},   32'(parking_capacity), 32'(m_cap()));
    chk({tag, ".free_count"}, 32'(free_count),       32'(m_free()));
    chk({tag, ".entry_grant"},32'(entry_grant),      32'(m_grant));
    chk({tag, ".grant_slot"}, 32'(grant_slot),       32'(m_slot));
    chk({tag, ".gate_open"},  32'(gate_open),        32'(m_gate_left > 0));
    chk({tag, ".exit_err"},   32'(exit_err),         32'(m_err));
  endtask

  // Drive at the falling edge, update model at the rising edge, check 1ns later.
  task automatic step(input string tag, input bit req, input bit en, input bit exr, input int exs);
    entry_req    = req;
    entry_enable = en;
    exit_req     = exr;
    exit_slot    = SLOT_W'(exs);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  int hi;
  int ngrant;
  int exp_slot;

  initial begin
    rst_n        = 1'b0;
    entry_req    = 1'b0;
    entry_enable = 1'b0;
    exit_req     = 1'b0;
    exit_slot    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // First admitted entry and gate-open width.
    step("t1_admit", 1, 1, 0, 0);
    chk("t1_cap", 32'(parking_capacity), 32'h01);
    chk("t1_free", 32'(free_count), 32'd7);
    chk("t1_grant", 32'(entry_grant), 32'd1);
    hi = int'(gate_open);
    for (int i = 0; i < 6; i++) begin
      step("t1_gate", 0, 0, 0, 0);
      hi += int'(gate_open);
    end
    chk("t1_gate_width", 32'(hi), 32'(GOC));

    // Fill the lot with entry_req held; grants must come in ascending order.
    ngrant   = 0;
    exp_slot = 1;
    for (int i = 0; i < 45; i++) begin
      step("t2_fill", 1, m_cap() != '1, 0, 0);
      if (entry_grant === 1'b1) begin
        chk("t2_order", 32'(grant_slot), 32'(exp_slot));
        exp_slot++;
        ngrant++;
      end
    end
    chk("t2_ngrant", 32'(ngrant), 32'd7);
    chk("t2_cap", 32'(parking_capacity), 32'hFF);
    chk("t2_free", 32'(free_count), 32'd0);

    // Full guard with entry_enable forced high.
    for (int i = 0; i < 3; i++) begin
      step("t3_full", 1, 1, 0, 0);
      chk("t3_no_grant", 32'(entry_grant), 32'd0);
      chk("t3_gate_shut", 32'(gate_open), 32'd0);
    end

    // Exits down to 0x0F, a legal exit, then an exit of a free slot.
    for (int s = 7; s >= 4; s--) step("t4_drain", 0, 0, 1, s);
    chk("t4_cap0F", 32'(parking_capacity), 32'h0F);
    step("t4_exit2", 0, 0, 1, 2);
    chk("t4_cap0B", 32'(parking_capacity), 32'h0B);
    chk("t4_free5", 32'(free_count), 32'd5);
    step("t4_exit6", 0, 0, 1, 6);
    chk("t4_err", 32'(exit_err), 32'd1);
    chk("t4_cap_same", 32'(parking_capacity), 32'h0B);
    step("t4_err_pulse", 0, 0, 0, 0);
    chk("t4_err_clear", 32'(exit_err), 32'd0);

    // Build 0x07, then simultaneous admit and exit of slot 0.
    step("t5_prep_exit3", 0, 0, 1, 3);
    step("t5_prep_admit", 1, 1, 0, 0);
    chk("t5_cap07", 32'(parking_capacity), 32'h07);
    repeat (5) step("t5_wait", 0, 0, 0, 0);
    step("t5_both", 1, 1, 1, 0);
    chk("t5_slot3", 32'(grant_slot), 32'd3);
    chk("t5_cap0E", 32'(parking_capacity), 32'h0E);
    chk("t5_free5", 32'(free_count), 32'd5);
    repeat (5) step("t5_wait2", 0, 0, 0, 0);

    // Reset during the second gate cycle with 0x03 occupied.
    step("t6_exit2", 0, 0, 1, 2);
    step("t6_exit3", 0, 0, 1, 3);
    step("t6_admit", 1, 1, 0, 0);
    chk("t6_cap03", 32'(parking_capacity), 32'h03);
    step("t6_gate2", 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gate", 32'(gate_open), 32'd0);
    chk("t6_rst_cap", 32'(parking_capacity), 32'h00);
    chk("t6_rst_grant", 32'(entry_grant), 32'd0);
    chk("t6_rst_free", 32'(free_count), 32'(NS));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("t6_after", 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit r_req = ($urandom_range(0, 3) != 0);
      bit r_en  = ($urandom_range(0, 4) != 0) ? (m_cap() != '1) : bit'($urandom_range(0, 1));
      bit r_exr = ($urandom_range(0, 3) == 0);
      int r_exs = int'($urandom_range(0, NS - 1));
      step("rand", r_req, r_en, r_exr, r_exs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
